// File: rtl/lwram_ctrl_if.sv
// Bus bundle between the chip-select/wait block, the LWRAM controller and
// the SDRAM/BRAM port.
//   CPU side : A, DI, DO, DCE_N, DOE_N, DWE_N, DWAIT_N
//   Mem side : MEM_A, MEM_D, MEM_BE, MEM_WR, MEM_REQ, MEM_Q, MEM_RDY
//   Status   : ERR (sticky timeout flag)
// The slave modport is the controller; the master modport is its environment
// (upstream strobes plus the memory responder).
interface lwram_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] A;
  logic [15:0]       DI;
  logic [15:0]       DO;
  logic              DCE_N;
  logic              DOE_N;
  logic [1:0]        DWE_N;
  logic              DWAIT_N;
  logic [ADDR_W-1:0] MEM_A;
  logic [15:0]       MEM_D;
  logic [1:0]        MEM_BE;
  logic              MEM_WR;
  logic              MEM_REQ;
  logic [15:0]       MEM_Q;
  logic              MEM_RDY;
  logic              ERR;

  modport master (
    output A, DI, DCE_N, DOE_N, DWE_N, MEM_Q, MEM_RDY,
    input  DO, DWAIT_N, MEM_A, MEM_D, MEM_BE, MEM_WR, MEM_REQ, ERR
  );

  modport slave (
    input  A, DI, DCE_N, DOE_N, DWE_N, MEM_Q, MEM_RDY,
    output DO, DWAIT_N, MEM_A, MEM_D, MEM_BE, MEM_WR, MEM_REQ, ERR
  );
endinterface

// File: rtl/lwram_ctrl.sv
// Low work RAM access controller.
// Turns SH-2 strobe cycles (DCE_N/DOE_N/DWE_N) into single-word
// request/ready transactions. Writes are posted through a one-deep buffer
// (or stall when POST_WR=0); reads stall the CPU via DWAIT_N until data
// returns. A request left unanswered for TIMEOUT cycles is force-completed
// and flags ERR.
// Ports:
//   CLK  - system clock
//   RST  - synchronous reset, active-high
//   bus  - lwram_ctrl_if.slave: CPU strobes/address/data, DWAIT_N, DO,
//          memory request port, ERR
module lwram_ctrl #(
  parameter int ADDR_W  = 19,
  parameter bit POST_WR = 1'b1,
  parameter int TIMEOUT = 255
) (
  input logic         CLK,
  input logic         RST,
  lwram_ctrl_if.slave bus
);

  // Counter holds 0..TIMEOUT-1; the last value is the forced-completion cycle.
  localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rd_s_q, wr_s_q;
  logic              rd_s_d, wr_s_d;
  logic              wbuf_v_q;
  logic [ADDR_W-1:0] wbuf_a_q;
  logic [15:0]       wbuf_d_q;
  logic [1:0]        wbuf_be_q;
  logic              wpend_q;
  logic [ADDR_W-1:0] wpend_a_q;
  logic [15:0]       wpend_d_q;
  logic [1:0]        wpend_be_q;
  logic              rd_pend_q;
  logic [ADDR_W-1:0] rd_a_q;
  logic [15:0]       do_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [15:0]       mem_d_q;
  logic [1:0]        mem_be_q;
  logic              mem_wr_q;
  logic              mem_req_q;
  logic              err_q;

  logic rd_start, wr_start, tmo, wr_done, rd_done, buf_free;
  logic cap_pend, cap_bus, stash, wr_stall;

  assign rd_s_d   = bus.DCE_N | bus.DOE_N;
  assign wr_s_d   = bus.DCE_N | (&bus.DWE_N);
  assign rd_start = rd_s_q & ~rd_s_d;
  assign wr_start = wr_s_q & ~wr_s_d;

  assign tmo      = (cnt_q == CNT_LAST);
  assign wr_done  = (state_q == ST_WRITE) && (bus.MEM_RDY || tmo);
  assign rd_done  = (state_q == ST_READ)  && (bus.MEM_RDY || tmo);
  // The buffer can take a new write in the very cycle its current one retires.
  assign buf_free = ~wbuf_v_q | wr_done;

  // A stalled write is stashed at its start edge so the capture later does
  // not depend on the CPU still driving A/DI.
  assign cap_pend = wpend_q & buf_free;
  assign cap_bus  = ~wpend_q & wr_start & buf_free;
  assign stash    = ~wpend_q & wr_start & ~buf_free;

  // Without posting, the CPU is held for as long as its write occupies the buffer.
  assign wr_stall = wpend_q | (!POST_WR && wbuf_v_q);

  assign bus.DWAIT_N = ~(rd_pend_q | wr_stall);
  assign bus.DO      = do_q;
  assign bus.MEM_A   = mem_a_q;
  assign bus.MEM_D   = mem_d_q;
  assign bus.MEM_BE  = mem_be_q;
  assign bus.MEM_WR  = mem_wr_q;
  assign bus.MEM_REQ = mem_req_q;
  assign bus.ERR     = err_q;

  // Buffer/address holding registers: pure data, no reset needed.
  always_ff @(posedge CLK) begin
    if (cap_pend) begin
      wbuf_a_q  <= wpend_a_q;
      wbuf_d_q  <= wpend_d_q;
      wbuf_be_q <= wpend_be_q;
    end else if (cap_bus) begin
      wbuf_a_q  <= bus.A;
      wbuf_d_q  <= bus.DI;
      wbuf_be_q <= ~bus.DWE_N;
    end
    if (stash) begin
      wpend_a_q  <= bus.A;
      wpend_d_q  <= bus.DI;
      wpend_be_q <= ~bus.DWE_N;
    end
    if (rd_start) begin
      rd_a_q <= bus.A;
    end
  end

  // Strobe edge detect, buffer/read flags and the memory-side FSM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_s_q    <= 1'b1;
      wr_s_q    <= 1'b1;
      wbuf_v_q  <= 1'b0;
      wpend_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      do_q      <= 16'h0000;
      mem_a_q   <= '0;
      mem_d_q   <= 16'h0000;
      mem_be_q  <= 2'b00;
      mem_wr_q  <= 1'b0;
      mem_req_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_s_q <= rd_s_d;
      wr_s_q <= wr_s_d;

      if (wr_done) begin
        wbuf_v_q <= 1'b0;
      end
      if (cap_pend || cap_bus) begin
        wbuf_v_q <= 1'b1;
      end
      if (cap_pend) begin
        wpend_q <= 1'b0;
      end else if (stash) begin
        wpend_q <= 1'b1;
      end

      if (rd_start) begin
        rd_pend_q <= 1'b1;
      end else if (rd_done) begin
        rd_pend_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          // Buffered write goes first so a following read observes it.
          if (wbuf_v_q) begin
            state_q   <= ST_WRITE;
            mem_req_q <= 1'b1;
            mem_wr_q  <= 1'b1;
            mem_a_q   <= wbuf_a_q;
            mem_d_q   <= wbuf_d_q;
            mem_be_q  <= wbuf_be_q;
          end else if (rd_pend_q) begin
            state_q   <= ST_READ;
            mem_req_q <= 1'b1;
            mem_wr_q  <= 1'b0;
            mem_a_q   <= rd_a_q;
            mem_be_q  <= 2'b11;
          end
        end
        ST_WRITE: begin
          if (wr_done) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            if (!bus.MEM_RDY) begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_READ: begin
          if (rd_done) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            if (bus.MEM_RDY) begin
              do_q <= bus.MEM_Q;
            end else begin
              do_q  <= 16'hFFFF;
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lwram_ctrl.sv
module tb_lwram_ctrl;
  localparam int AW  = 19;
  localparam int TMO = 16;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] a;
    logic [15:0]   d;
    logic [1:0]    be;
  } op_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  lwram_ctrl_if #(.ADDR_W(AW)) bus ();

  lwram_ctrl #(.ADDR_W(AW), .POST_WR(1'b1), .TIMEOUT(TMO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Memory device: latency-programmable responder plus a log of every
  // transaction it completed.
  op_t         oplog[$];
  logic [15:0] dev[int];
  int          rdy_lat   = 3;
  bit          rdy_en    = 1'b1;
  int          pulse_req = 0;
  logic [15:0] pulse_q   = 16'h0;

  initial begin : responder
    int cnt;
    int lat;
    int pulse_ack;
    logic [15:0] old;
    logic [15:0] mask;
    cnt = 0; lat = 1; pulse_ack = 0;
    bus.MEM_RDY = 1'b0;
    bus.MEM_Q   = 16'h0;
    forever begin
      @(posedge CLK); #1;
      if (bus.MEM_RDY) begin
        bus.MEM_RDY = 1'b0;
        cnt = 0;
      end else if (pulse_req != pulse_ack) begin
        pulse_ack   = pulse_req;
        bus.MEM_Q   = pulse_q;
        bus.MEM_RDY = 1'b1;
      end else if (bus.MEM_REQ && rdy_en) begin
        if (cnt == 0) lat = rdy_lat;
        cnt++;
        if (cnt >= lat) begin
          if (bus.MEM_WR) begin
            old  = dev.exists(int'(bus.MEM_A)) ? dev[int'(bus.MEM_A)] : 16'h0;
            mask = {{8{bus.MEM_BE[1]}}, {8{bus.MEM_BE[0]}}};
            dev[int'(bus.MEM_A)] = (old & ~mask) | (bus.MEM_D & mask);
          end else begin
            bus.MEM_Q = dev.exists(int'(bus.MEM_A)) ? dev[int'(bus.MEM_A)] : 16'h0;
          end
          oplog.push_back({bus.MEM_WR, bus.MEM_A, bus.MEM_D, bus.MEM_BE});
          bus.MEM_RDY = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference memory at CPU level: updated in program order at write time.
  logic [15:0] refm[int];

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] m;
    m = {{8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  task automatic cpu_write(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] dwe);
    int stall;
    @(negedge CLK);
    bus.A = a; bus.DI = d; bus.DWE_N = dwe; bus.DCE_N = 1'b0;
    @(negedge CLK);
    stall = 0;
    while (bus.DWAIT_N !== 1'b1 && stall < 200) begin
      stall++;
      @(negedge CLK);
    end
    n_cmp++;
    if (bus.DWAIT_N !== 1'b1) begin
      n_fail++;
      $display("FAIL cpu_write_release: DWAIT_N=%b required 1", bus.DWAIT_N);
    end
    bus.DCE_N = 1'b1; bus.DWE_N = 2'b11;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, output logic [15:0] q);
    int stall;
    @(negedge CLK);
    bus.A = a; bus.DOE_N = 1'b0; bus.DCE_N = 1'b0;
    @(negedge CLK);
    stall = 0;
    while (bus.DWAIT_N !== 1'b1 && stall < 200) begin
      stall++;
      @(negedge CLK);
    end
    n_cmp++;
    if (bus.DWAIT_N !== 1'b1) begin
      n_fail++;
      $display("FAIL cpu_read_release: DWAIT_N=%b required 1", bus.DWAIT_N);
    end
    q = bus.DO;
    bus.DCE_N = 1'b1; bus.DOE_N = 1'b1;
  endtask

  // Watches one memory request from the current negedge: first request
  // snapshot, stability while requested, any DWAIT_N low, MEM_REQ after RDY.
  task automatic observe_req(input int maxcyc, output logic got, output op_t first,
                             output logic stable, output logic dwait_low,
                             output logic req_after);
    logic seen_rdy;
    op_t  cur;
    got = 1'b0; stable = 1'b1; dwait_low = 1'b0; req_after = 1'bx;
    seen_rdy = 1'b0; first = '0;
    for (int i = 0; i < maxcyc; i++) begin
      if (bus.DWAIT_N !== 1'b1) dwait_low = 1'b1;
      if (seen_rdy) begin
        req_after = bus.MEM_REQ;
        break;
      end
      if (bus.MEM_REQ) begin
        cur = {bus.MEM_WR, bus.MEM_A, bus.MEM_D, bus.MEM_BE};
        if (!got) begin
          got = 1'b1;
          first = cur;
        end else if (cur !== first) begin
          stable = 1'b0;
        end
        if (bus.MEM_RDY) seen_rdy = 1'b1;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (bus.DO !== 16'h0 || bus.DWAIT_N !== 1'b1 || bus.ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cpu: DO=%h DWAIT_N=%b ERR=%b required 0000 1 0",
               bus.DO, bus.DWAIT_N, bus.ERR);
    end
    n_cmp++;
    if ({bus.MEM_A, bus.MEM_D, bus.MEM_BE, bus.MEM_WR, bus.MEM_REQ} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: A=%h D=%h BE=%b WR=%b REQ=%b required all 0",
               bus.MEM_A, bus.MEM_D, bus.MEM_BE, bus.MEM_WR, bus.MEM_REQ);
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_posted_write();
    logic got, stable, dlow, req_after;
    op_t  first;
    rdy_lat = 3;
    @(negedge CLK);
    bus.A = 19'h01234; bus.DI = 16'hBEEF; bus.DWE_N = 2'b00; bus.DCE_N = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (bus.DWAIT_N !== 1'b1) begin
      n_fail++;
      $display("FAIL posted_no_stall: DWAIT_N=%b required 1", bus.DWAIT_N);
    end
    bus.DCE_N = 1'b1; bus.DWE_N = 2'b11;
    observe_req(40, got, first, stable, dlow, req_after);
    n_cmp++;
    if (got !== 1'b1 || first !== {1'b1, 19'h01234, 16'hBEEF, 2'b11}) begin
      n_fail++;
      $display("FAIL posted_req: got=%b op=%h required 1 %h", got, first,
               {1'b1, 19'h01234, 16'hBEEF, 2'b11});
    end
    n_cmp++;
    if (stable !== 1'b1 || dlow !== 1'b0) begin
      n_fail++;
      $display("FAIL posted_stable: stable=%b dwait_low=%b required 1 0", stable, dlow);
    end
    n_cmp++;
    if (req_after !== 1'b0) begin
      n_fail++;
      $display("FAIL posted_req_drop: MEM_REQ=%b required 0", req_after);
    end
    refm[int'(19'h01234)] = 16'hBEEF;
  endtask

  task automatic test_byte_write();
    logic got, stable, dlow, req_after;
    op_t  first;
    logic [AW-1:0] a;
    a = AW'($urandom_range(16'h2000, 16'h2FFF));
    rdy_lat = 2;
    @(negedge CLK);
    bus.A = a; bus.DI = 16'h12AB; bus.DWE_N = 2'b10; bus.DCE_N = 1'b0;
    @(negedge CLK);
    bus.DCE_N = 1'b1; bus.DWE_N = 2'b11;
    observe_req(40, got, first, stable, dlow, req_after);
    n_cmp++;
    if (got !== 1'b1 || first !== {1'b1, a, 16'h12AB, 2'b01}) begin
      n_fail++;
      $display("FAIL byte_write: got=%b op=%h required 1 %h", got, first,
               {1'b1, a, 16'h12AB, 2'b01});
    end
    refm[int'(a)] = merge(refm.exists(int'(a)) ? refm[int'(a)] : 16'h0, 16'h12AB, 2'b01);
  endtask

  task automatic test_buffer_full();
    int   base;
    logic low_bad, saw;
    base = oplog.size();
    rdy_lat = 10;
    @(negedge CLK);
    bus.A = 19'h00100; bus.DI = 16'h1111; bus.DWE_N = 2'b00; bus.DCE_N = 1'b0;
    @(negedge CLK);
    bus.DCE_N = 1'b1; bus.DWE_N = 2'b11;
    @(negedge CLK);
    bus.A = 19'h00200; bus.DI = 16'h2222; bus.DWE_N = 2'b00; bus.DCE_N = 1'b0;
    @(negedge CLK);
    low_bad = 1'b0; saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.DWAIT_N !== 1'b0) low_bad = 1'b1;
      if (bus.MEM_RDY === 1'b1) begin
        saw = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    n_cmp++;
    if (low_bad !== 1'b0 || saw !== 1'b1) begin
      n_fail++;
      $display("FAIL bufful_stall: early_release=%b saw_rdy=%b required 0 1", low_bad, saw);
    end
    @(negedge CLK);
    n_cmp++;
    if (bus.DWAIT_N !== 1'b1) begin
      n_fail++;
      $display("FAIL bufful_release: DWAIT_N=%b required 1", bus.DWAIT_N);
    end
    bus.DCE_N = 1'b1; bus.DWE_N = 2'b11;
    for (int i = 0; i < 60 && oplog.size() < base + 2; i++) @(negedge CLK);
    n_cmp++;
    if (oplog.size() < base + 2) begin
      n_fail++;
      $display("FAIL bufful_count: ops=%0d required %0d", oplog.size() - base, 2);
    end else if (oplog[base] !== {1'b1, 19'h00100, 16'h1111, 2'b11} ||
                 oplog[base+1] !== {1'b1, 19'h00200, 16'h2222, 2'b11}) begin
      n_fail++;
      $display("FAIL bufful_data: op0=%h op1=%h required %h %h", oplog[base], oplog[base+1],
               {1'b1, 19'h00100, 16'h1111, 2'b11}, {1'b1, 19'h00200, 16'h2222, 2'b11});
    end
    refm[int'(19'h00100)] = 16'h1111;
    refm[int'(19'h00200)] = 16'h2222;
  endtask

  task automatic test_read_after_write();
    int   base;
    logic prev, saw;
    base = oplog.size();
    rdy_lat = 2;
    cpu_write(19'h00010, 16'h5555, 2'b00);
    refm[int'(19'h00010)] = 16'h5555;
    @(negedge CLK);
    bus.A = 19'h00010; bus.DOE_N = 1'b0; bus.DCE_N = 1'b0;
    @(negedge CLK);
    prev = 1'b0; saw = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (prev) begin
        saw = 1'b1;
        break;
      end
      prev = bus.MEM_RDY & bus.MEM_REQ & ~bus.MEM_WR;
      @(negedge CLK);
    end
    n_cmp++;
    if (saw !== 1'b1 || bus.DWAIT_N !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_release: saw_rdy=%b DWAIT_N=%b required 1 1", saw, bus.DWAIT_N);
    end
    n_cmp++;
    if (bus.DO !== 16'h5555) begin
      n_fail++;
      $display("FAIL raw_data: DO=%h required 5555", bus.DO);
    end
    bus.DCE_N = 1'b1; bus.DOE_N = 1'b1;
    n_cmp++;
    if (oplog.size() < base + 2) begin
      n_fail++;
      $display("FAIL raw_order: ops=%0d required 2", oplog.size() - base);
    end else if (oplog[base].wr !== 1'b1 || oplog[base+1].wr !== 1'b0 ||
                 oplog[base+1].a !== 19'h00010) begin
      n_fail++;
      $display("FAIL raw_order: op0.wr=%b op1.wr=%b op1.a=%h required 1 0 00010",
               oplog[base].wr, oplog[base+1].wr, oplog[base+1].a);
    end
  endtask

  task automatic test_random();
    int            base, nw, nr, wi, ri;
    op_t           expw[$];
    logic [AW-1:0] expr[$];
    logic [AW-1:0] a;
    logic [15:0]   d, q, exp;
    logic [1:0]    dwe;
    base = oplog.size();
    for (int k = 0; k < 40; k++) begin
      rdy_lat = $urandom_range(1, 6);
      a = ($urandom_range(0, 1) == 1) ? 19'h7FFF8 : 19'h40000;
      a = a + AW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        d = 16'($urandom);
        case ($urandom_range(0, 2))
          0:       dwe = 2'b00;
          1:       dwe = 2'b01;
          default: dwe = 2'b10;
        endcase
        refm[int'(a)] = merge(refm.exists(int'(a)) ? refm[int'(a)] : 16'h0, d, ~dwe);
        expw.push_back({1'b1, a, d, ~dwe});
        cpu_write(a, d, dwe);
      end else begin
        exp = refm.exists(int'(a)) ? refm[int'(a)] : 16'h0;
        expr.push_back(a);
        cpu_read(a, q);
        n_cmp++;
        if (q !== exp) begin
          n_fail++;
          $display("FAIL random_read[%0d]: addr=%h DO=%h required %h", k, a, q, exp);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    repeat (40) @(negedge CLK);
    nw = 0; nr = 0; wi = 0; ri = 0;
    for (int i = base; i < oplog.size(); i++) begin
      if (oplog[i].wr) begin
        if (wi < expw.size() && oplog[i] !== expw[wi]) nw++;
        wi++;
      end else begin
        if (ri < expr.size() && oplog[i].a !== expr[ri]) nr++;
        ri++;
      end
    end
    n_cmp++;
    if (wi != expw.size() || nw != 0) begin
      n_fail++;
      $display("FAIL random_writes: issued=%0d bad=%0d required %0d 0", wi, nw, expw.size());
    end
    n_cmp++;
    if (ri != expr.size() || nr != 0) begin
      n_fail++;
      $display("FAIL random_read_addr: issued=%0d bad=%0d required %0d 0", ri, nr, expr.size());
    end
  endtask

  task automatic test_timeout();
    int reqc;
    n_cmp++;
    if (bus.ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err_before: ERR=%b required 0", bus.ERR);
    end
    rdy_en = 1'b0;
    @(negedge CLK);
    bus.A = 19'h00321; bus.DOE_N = 1'b0; bus.DCE_N = 1'b0;
    @(negedge CLK);
    reqc = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.DWAIT_N === 1'b1) break;
      if (bus.MEM_REQ === 1'b1) reqc++;
      @(negedge CLK);
    end
    n_cmp++;
    if (reqc != TMO) begin
      n_fail++;
      $display("FAIL timeout_cycles: req_cycles=%0d required %0d", reqc, TMO);
    end
    n_cmp++;
    if (bus.DWAIT_N !== 1'b1 || bus.DO !== 16'hFFFF || bus.ERR !== 1'b1 || bus.MEM_REQ !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_done: DWAIT_N=%b DO=%h ERR=%b REQ=%b required 1 FFFF 1 0",
               bus.DWAIT_N, bus.DO, bus.ERR, bus.MEM_REQ);
    end
    bus.DCE_N = 1'b1; bus.DOE_N = 1'b1;
    rdy_en = 1'b1;
    rdy_lat = 2;
    cpu_write(19'h00322, 16'hCAFE, 2'b00);
    refm[int'(19'h00322)] = 16'hCAFE;
    repeat (6) @(negedge CLK);
    n_cmp++;
    if (bus.ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: ERR=%b required 1", bus.ERR);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] q;
    rdy_en = 1'b0;
    @(negedge CLK);
    bus.A = 19'h00555; bus.DOE_N = 1'b0; bus.DCE_N = 1'b0;
    for (int i = 0; i < 20 && bus.MEM_REQ !== 1'b1; i++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (bus.MEM_REQ !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_inread: MEM_REQ=%b required 1", bus.MEM_REQ);
    end
    RST = 1'b1;
    bus.DCE_N = 1'b1; bus.DOE_N = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({bus.DO, bus.DWAIT_N, bus.MEM_A, bus.MEM_D, bus.MEM_BE, bus.MEM_WR, bus.MEM_REQ, bus.ERR}
        !== {16'h0, 1'b1, 19'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_outputs: DO=%h DWAIT_N=%b A=%h D=%h BE=%b WR=%b REQ=%b ERR=%b required reset values",
               bus.DO, bus.DWAIT_N, bus.MEM_A, bus.MEM_D, bus.MEM_BE, bus.MEM_WR, bus.MEM_REQ, bus.ERR);
    end
    RST = 1'b0;
    pulse_q = 16'hABCD;
    pulse_req++;
    repeat (4) @(negedge CLK);
    n_cmp++;
    if (bus.DO !== 16'h0 || bus.MEM_REQ !== 1'b0 || bus.DWAIT_N !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_late_rdy: DO=%h REQ=%b DWAIT_N=%b required 0000 0 1",
               bus.DO, bus.MEM_REQ, bus.DWAIT_N);
    end
    rdy_en = 1'b1;
    rdy_lat = 3;
    cpu_write(19'h00555, 16'h7E57, 2'b00);
    cpu_read(19'h00555, q);
    n_cmp++;
    if (q !== 16'h7E57) begin
      n_fail++;
      $display("FAIL rstmid_recover: DO=%h required 7E57", q);
    end
  endtask

  initial begin : main
    bus.A = '0; bus.DI = 16'h0; bus.DCE_N = 1'b1; bus.DOE_N = 1'b1; bus.DWE_N = 2'b11;
    RST = 1'b1;
    test_reset();
    test_posted_write();
    test_byte_write();
    test_buffer_full();
    test_read_after_write();
    test_random();
    test_timeout();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
